// File: rtl/rom_stream_reader.sv
// rom_stream_reader: bursts words out of a 1-cycle-latency synchronous ROM into a ready/valid stream
// through a 2-entry FIFO, replaying reads that find the FIFO full so no word is dropped.
module rom_stream_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int ROM_SIZE   = 220
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state;
  logic [ADDR_WIDTH:0] remaining;
  logic v1, v2, l1, l2;
  logic [ADDR_WIDTH-1:0] a2;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0] lst;
  logic rd, wr;
  logic [1:0] count;
  logic idle, bad, accept, pop, push, replay, issue, last_pop;
  logic [2:0] load;
  logic [ADDR_WIDTH-1:0] nxt;
  always_comb begin
    idle = state == IDLE;
    bad = 32'(base_addr) >= ROM_SIZE || 32'(length) > ROM_SIZE;
    accept = idle && start && !bad && length != '0;
    o_valid = count != 2'd0;
    o_data = mem[rd];
    o_last = o_valid && lst[rd];
    busy = !idle;
    pop = o_valid && o_ready;
    push = v2 && (count != 2'd2 || pop);
    replay = v2 && !push;
    load = 3'(count) + 3'(v1) + 3'(v2) - 3'(pop);
    issue = !idle && remaining != '0 && load <= 3'd2;
    nxt = (32'(rom_addr) == ROM_SIZE - 1) ? '0 : rom_addr + 1'b1;
    last_pop = pop && lst[rd];
  end
  // A blocked data-stage word is re-read from its own address; the squashed
  // address-stage read goes back into the remaining count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      {v1, v2, l1, l2} <= '0;
      a2 <= '0;
      rom_addr <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      lst <= '0;
      {rd, wr} <= '0;
      count <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= idle && start && bad;
      done <= (idle && start && !bad && length == '0) || (!idle && last_pop);
      v1 <= accept || issue || replay;
      v2 <= v1 && !replay;
      a2 <= rom_addr;
      l2 <= l1;
      if (accept) begin
        rom_addr <= base_addr;
        l1 <= length == 1;
        remaining <= length - 1'b1;
      end else if (issue) begin
        rom_addr <= nxt;
        l1 <= remaining == 1;
        remaining <= remaining - 1'b1;
      end else if (replay) begin
        rom_addr <= a2;
        l1 <= l2;
        remaining <= remaining + (ADDR_WIDTH+1)'(v1);
      end
      if (push) begin
        mem[wr] <= rom_data;
        lst[wr] <= l2;
        wr <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (accept) state <= RUN;
      else if (!idle && last_pop) state <= IDLE;
      else if (state == RUN && remaining == '0) state <= DRAIN;
    end
  end
endmodule
